// File: rtl/int2flt_seq_if.sv
// Byte-wide data memory port used by the int2flt_seq converter.
// The master drives the address and write side. The slave returns combinational read data.
interface int2flt_seq_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic [7:0]        mem_wr_data;
    logic              mem_wr_en;

    modport master (
        output mem_addr,
        output mem_wr_data,
        output mem_wr_en,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_data,
        input  mem_wr_en,
        output mem_rd_data
    );
endinterface

// File: rtl/int2flt_seq.sv
// Sequential converter from a 16-bit two's-complement integer to an IEEE-754 half float.
// It reads the operand bytes from memory, normalises one bit per cycle, rounds to nearest-even, and writes the result back.
//
// state | meaning
// RD_HI | fetch operand MSB byte
// RD_LO | fetch operand LSB byte
// PREP  | take sign and magnitude, seed exponent, detect zero
// NORM  | shift magnitude left until bit 15 is set
// ROUND | round to nearest-even and assemble result
// WR_HI | write result MSB byte
// WR_LO | write result LSB byte
// DONE  | conversion finished, hold until reset
module int2flt_seq #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] IN_ADDR  = ADDR_W'(64),
    parameter logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(66)
) (
    input  logic              clk,
    input  logic              reset,
    int2flt_seq_if.master     bus,
    output logic              done
);
    localparam logic [ADDR_W-1:0] IN_ADDR_LO  = IN_ADDR + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OUT_ADDR_LO = OUT_ADDR + ADDR_W'(1);

    typedef enum logic [2:0] {
        RD_HI, RD_LO, PREP, NORM, ROUND, WR_HI, WR_LO, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  op_hi, op_hi_nxt;
    logic [7:0]  op_lo, op_lo_nxt;
    logic        sign, sign_nxt;
    logic [15:0] mag, mag_nxt;
    logic [4:0]  exp, exp_nxt;
    logic [15:0] result, result_nxt;

    logic [15:0] operand;
    logic [15:0] abs_val;
    logic        round_inc;
    logic [10:0] man_rnd;

    assign operand   = {op_hi, op_lo};
    assign abs_val   = operand[15] ? (~operand + 16'd1) : operand;
    assign round_inc = mag[4] & ((|mag[3:0]) | mag[5]);
    assign man_rnd   = {1'b0, mag[14:5]} + {10'd0, round_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RD_HI;
            op_hi  <= 8'd0;
            op_lo  <= 8'd0;
            sign   <= 1'b0;
            mag    <= 16'd0;
            exp    <= 5'd0;
            result <= 16'd0;
        end else begin
            state  <= state_nxt;
            op_hi  <= op_hi_nxt;
            op_lo  <= op_lo_nxt;
            sign   <= sign_nxt;
            mag    <= mag_nxt;
            exp    <= exp_nxt;
            result <= result_nxt;
        end
    end

    // Outputs decode only registered state and result, so read data never reaches an output directly.
    always_comb begin
        state_nxt       = state;
        op_hi_nxt       = op_hi;
        op_lo_nxt       = op_lo;
        sign_nxt        = sign;
        mag_nxt         = mag;
        exp_nxt         = exp;
        result_nxt      = result;
        bus.mem_addr    = IN_ADDR_LO;
        bus.mem_wr_data = 8'd0;
        bus.mem_wr_en   = 1'b0;
        done            = 1'b0;

        case (state)
            RD_HI: begin
                bus.mem_addr = IN_ADDR;
                op_hi_nxt    = bus.mem_rd_data;
                state_nxt    = RD_LO;
            end
            RD_LO: begin
                bus.mem_addr = IN_ADDR_LO;
                op_lo_nxt    = bus.mem_rd_data;
                state_nxt    = PREP;
            end
            PREP: begin
                sign_nxt = operand[15];
                mag_nxt  = abs_val;
                exp_nxt  = 5'd30;
                if (operand == 16'd0) begin
                    result_nxt = 16'd0;
                    state_nxt  = WR_HI;
                end else if (abs_val[15]) begin
                    state_nxt = ROUND;
                end else begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                // Leave as soon as the shift lands the leading one in bit 15, so no idle cycle is spent.
                if (mag[15]) begin
                    state_nxt = ROUND;
                end else begin
                    mag_nxt = {mag[14:0], 1'b0};
                    exp_nxt = exp - 5'd1;
                    if (mag[14]) begin
                        state_nxt = ROUND;
                    end
                end
            end
            ROUND: begin
                if (man_rnd[10]) begin
                    result_nxt = {sign, exp + 5'd1, 10'd0};
                end else begin
                    result_nxt = {sign, exp, man_rnd[9:0]};
                end
                state_nxt = WR_HI;
            end
            WR_HI: begin
                bus.mem_addr    = OUT_ADDR;
                bus.mem_wr_data = result[15:8];
                bus.mem_wr_en   = 1'b1;
                state_nxt       = WR_LO;
            end
            WR_LO: begin
                bus.mem_addr    = OUT_ADDR_LO;
                bus.mem_wr_data = result[7:0];
                bus.mem_wr_en   = 1'b1;
                state_nxt       = DONE;
            end
            DONE: begin
                bus.mem_addr = OUT_ADDR_LO;
                done         = 1'b1;
            end
            default: begin
                state_nxt = RD_HI;
            end
        endcase
    end
endmodule

// File: tb/tb_int2flt_seq.sv
// Bench for int2flt_seq: a memory model plus an integer-arithmetic reference for round-to-nearest-even half conversion.
// A per-cycle compare process checks the write strobes, the address, the data and done against the expected latency.
module tb_int2flt_seq;
    localparam int         ADDR_W   = 8;
    localparam logic [7:0] IN_ADDR  = 8'd64;
    localparam logic [7:0] OUT_ADDR = 8'd66;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done;
    always #5 clk = ~clk;

    int2flt_seq_if #(.ADDR_W(ADDR_W)) bus ();

    int2flt_seq #(.ADDR_W(ADDR_W), .IN_ADDR(IN_ADDR), .OUT_ADDR(OUT_ADDR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .done  (done)
    );

    logic [7:0]  mem [256];
    logic [15:0] op_reg = 16'd0;
    logic        clear_out = 1'b0;
    int          wr_count = 0;

    assign bus.mem_rd_data = (bus.mem_addr == IN_ADDR) ? op_reg[15:8] :
                             (bus.mem_addr == IN_ADDR + 8'd1) ? op_reg[7:0] :
                             mem[bus.mem_addr];

    always @(posedge clk) begin
        if (clear_out) begin
            mem[OUT_ADDR]        <= 8'hAA;
            mem[OUT_ADDR + 8'd1] <= 8'hAA;
            wr_count             <= 0;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
            wr_count          <= wr_count + 1;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s actual=%0h expected=%0h (operand %04h)", name, act, expv, op_reg);
    endtask

    // Reference: exact integer magnitude, scale to an 11-bit significand, round half to even.
    function automatic logic [15:0] ref_half(input logic [15:0] x);
        int v, a, e, q, rem, half, sh;
        logic s;
        if (x == 16'd0) return 16'd0;
        v = int'($signed(x));
        s = (v < 0);
        a = s ? -v : v;
        e = 0;
        while ((1 << (e + 1)) <= a) e++;
        if (e <= 10) begin
            q = a << (10 - e);
        end else begin
            sh   = e - 10;
            q    = a >> sh;
            rem  = a - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        return {s, 5'(e + 15), 10'(q - 1024)};
    endfunction

    function automatic int ref_lat(input logic [15:0] x);
        int v, a, p;
        if (x == 16'd0) return 5;
        v = int'($signed(x));
        a = (v < 0) ? -v : v;
        p = 0;
        while ((1 << (p + 1)) <= a) p++;
        return 6 + (15 - p);
    endfunction

    logic [15:0] exp_res = 16'd0;
    int          exp_lat = 0;
    logic        active = 1'b0;
    int          cnt = 0;

    always @(posedge clk) begin
        if (reset) cnt <= 0;
        else cnt <= cnt + 1;
    end

    // Per-cycle compare against the expected timeline of one conversion.
    always @(negedge clk) begin
        if (active && !reset) begin
            if (cnt == 0) check("rd_addr_start", 32'(bus.mem_addr), 32'(IN_ADDR));
            check("wr_en", 32'(bus.mem_wr_en), 32'((cnt == exp_lat - 2) || (cnt == exp_lat - 1)));
            check("done", 32'(done), 32'(cnt >= exp_lat));
            if (cnt == exp_lat - 2) begin
                check("wr_hi_addr", 32'(bus.mem_addr), 32'(OUT_ADDR));
                check("wr_hi_data", 32'(bus.mem_wr_data), 32'(exp_res[15:8]));
            end
            if (cnt == exp_lat - 1) begin
                check("wr_lo_addr", 32'(bus.mem_addr), 32'(OUT_ADDR + 8'd1));
                check("wr_lo_data", 32'(bus.mem_wr_data), 32'(exp_res[7:0]));
            end
        end
    end

    task automatic start(input logic [15:0] op);
        reset     = 1'b1;
        op_reg    = op;
        clear_out = 1'b1;
        exp_res   = ref_half(op);
        exp_lat   = ref_lat(op);
        repeat (2) @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_wr_en", 32'(bus.mem_wr_en), 32'd0);
        clear_out = 1'b0;
        reset     = 1'b0;
        active    = 1'b1;
    endtask

    task automatic run_trial(input logic [15:0] op);
        int k;
        start(op);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(exp_lat));
        repeat (3) @(negedge clk);
        check("done_hold", 32'(done), 32'd1);
        check("wr_count", 32'(wr_count), 32'd2);
        check("mem_out", 32'({mem[OUT_ADDR], mem[OUT_ADDR + 8'd1]}), 32'(exp_res));
    endtask

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t dir [9] = '{
        '{16'h0000, 16'h0000, 5},
        '{16'h0001, 16'h3C00, 21},
        '{16'hFFFF, 16'hBC00, 21},
        '{16'h8000, 16'hF800, 6},
        '{16'h7FFF, 16'h7800, 7},
        '{16'h0FFF, 16'h6C00, 10},
        '{16'h0801, 16'h6800, 10},
        '{16'h0803, 16'h6802, 10},
        '{16'h0805, 16'h6802, 10}
    };

    initial begin
        logic [15:0] op;
        repeat (2) @(negedge clk);

        foreach (dir[i]) begin
            op_reg = dir[i].op;
            check("model_res", 32'(ref_half(dir[i].op)), 32'(dir[i].res));
            check("model_lat", 32'(ref_lat(dir[i].op)), 32'(dir[i].lat));
            run_trial(dir[i].op);
            check("dir_res", 32'({mem[OUT_ADDR], mem[OUT_ADDR + 8'd1]}), 32'(dir[i].res));
        end

        // Abort during NORM: reset must suppress any write and done.
        start(16'h0001);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("abort_wr_count", 32'(wr_count), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_wr_count_hold", 32'(wr_count), 32'd0);
        run_trial(16'h0001);
        check("abort_rerun_res", 32'({mem[OUT_ADDR], mem[OUT_ADDR + 8'd1]}), 32'h3C00);

        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 3))
                0: op = 16'($urandom);
                1: op = 16'($urandom_range(0, 2047));
                2: op = 16'(-$urandom_range(1, 4096));
                default: op = 16'($urandom) | 16'h0010;
            endcase
            run_trial(op);
        end

        active = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
